// File: rtl/vfx_pkg.sv
// Shared definitions for the video effects path: filter mode encoding,
// pixel width and the button debouncer state encoding.
package vfx_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_GRAY   = 2'd2,
    MODE_THRESH = 2'd3
  } filter_mode_e;

  localparam int NUM_FILTER_MODES = 4;
  localparam int PIXEL_W          = 12;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_PRESS_CNT = 2'd1,
    DB_HELD      = 2'd2,
    DB_REL_CNT   = 2'd3
  } db_state_e;

endpackage

// File: rtl/filter_mode_scheduler_if.sv
// Control bundle between the board inputs / frame timing and the mode
// scheduler. The master side drives button, auto enable and start-of-frame;
// the slave side (the scheduler) returns the committed and pending modes.
interface filter_mode_scheduler_if #(
  parameter int NUM_MODES = 4,
  parameter int MW        = $clog2(NUM_MODES)
) ();

  logic                 btn_next;
  logic                 auto_en;
  logic                 sof;
  logic [MW-1:0]        mode_active;
  logic [MW-1:0]        mode_pending;
  logic [NUM_MODES-1:0] filter_sel;
  logic                 mode_changed;

  modport master (
    output btn_next, auto_en, sof,
    input  mode_active, mode_pending, filter_sel, mode_changed
  );

  modport slave (
    input  btn_next, auto_en, sof,
    output mode_active, mode_pending, filter_sel, mode_changed
  );

endinterface

// File: rtl/button_debouncer.sv
// Four-state button debouncer. A press is accepted after DEBOUNCE_CYCLES
// consecutive high samples and produces a single registered press_evt;
// the button must then be seen low for DEBOUNCE_CYCLES samples before
// another press can start, so holding or glitching never auto-repeats.
module button_debouncer
  import vfx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press_evt
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_e     r_state;
  db_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_press_evt;
  logic          w_press_nxt;

  // Next-state logic: the counter holds how many consecutive samples of the
  // level being qualified have been seen, including the one that left IDLE/HELD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (i_btn) begin
          w_state_nxt = DB_PRESS_CNT;
          w_cnt_nxt   = CW'(1);
        end
      end
      DB_PRESS_CNT: begin
        if (!i_btn) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = DB_HELD;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DB_HELD: begin
        if (!i_btn) begin
          w_state_nxt = DB_REL_CNT;
          w_cnt_nxt   = CW'(1);
        end
      end
      DB_REL_CNT: begin
        if (i_btn) begin
          w_state_nxt = DB_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and the one-cycle press event register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= DB_IDLE;
      r_cnt       <= '0;
      r_press_evt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_press_evt <= w_press_nxt;
    end
  end

  assign o_press_evt = r_press_evt;

endmodule

// File: rtl/filter_mode_scheduler.sv
// Chooses which pixel filter drives the video path. Button presses and the
// auto-cycle timer only move the pending mode; the active mode follows it
// exclusively on start-of-frame so a frame is never split between filters.
module filter_mode_scheduler
  import vfx_pkg::*;
#(
  parameter int NUM_MODES       = NUM_FILTER_MODES,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_FRAMES     = 60,
  parameter int MW              = $clog2(NUM_MODES)
) (
  input logic clk,
  input logic reset,
  filter_mode_scheduler_if.slave bus
);

  localparam int             FCW        = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [MW-1:0]  LAST_MODE  = MW'(NUM_MODES - 1);
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(AUTO_FRAMES - 1);

  logic [MW-1:0]        r_mode_active;
  logic [MW-1:0]        r_mode_pending;
  logic [FCW-1:0]       r_frame_cnt;
  logic                 r_mode_changed;
  logic                 w_press_evt;
  logic [MW-1:0]        w_pending_inc;
  logic [MW-1:0]        w_active_inc;
  logic                 w_auto_fire;
  logic [MW-1:0]        w_next_pending;
  logic [NUM_MODES-1:0] w_filter_sel;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .i_btn      (bus.btn_next),
    .o_press_evt(w_press_evt)
  );

  // Mode arithmetic wraps explicitly at NUM_MODES-1 so non-power-of-two
  // mode counts never reach an unused index. A manual press outranks the
  // auto trigger, and auto only advances when nothing is already queued.
  always_comb begin
    w_pending_inc  = (r_mode_pending == LAST_MODE) ? '0 : r_mode_pending + 1'b1;
    w_active_inc   = (r_mode_active == LAST_MODE) ? '0 : r_mode_active + 1'b1;
    w_auto_fire    = bus.auto_en && bus.sof && (r_frame_cnt == LAST_FRAME);
    w_next_pending = r_mode_pending;
    if (w_press_evt) begin
      w_next_pending = w_pending_inc;
    end else if (w_auto_fire && (r_mode_pending == r_mode_active)) begin
      w_next_pending = w_active_inc;
    end
  end

  // Pending/active mode registers; the commit and the change pulse happen
  // on the edge that samples sof.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_active  <= '0;
      r_mode_pending <= '0;
      r_mode_changed <= 1'b0;
    end else if (bus.sof) begin
      r_mode_active  <= w_next_pending;
      r_mode_pending <= w_next_pending;
      r_mode_changed <= (w_next_pending != r_mode_active);
    end else begin
      r_mode_changed <= 1'b0;
      if (w_press_evt) begin
        r_mode_pending <= w_pending_inc;
      end
    end
  end

  // Auto-cycle frame counter: idle at zero while auto is off, restarted by
  // a manual press, wrapping after AUTO_FRAMES start-of-frame pulses.
  always_ff @(posedge clk) begin
    if (reset || !bus.auto_en || w_press_evt) begin
      r_frame_cnt <= '0;
    end else if (bus.sof) begin
      r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + 1'b1;
    end
  end

  // One-hot decode of the active mode feeding the filter output mux.
  always_comb begin
    w_filter_sel = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      w_filter_sel[i] = (r_mode_active == MW'(i));
    end
  end

  assign bus.mode_active  = r_mode_active;
  assign bus.mode_pending = r_mode_pending;
  assign bus.filter_sel   = w_filter_sel;
  assign bus.mode_changed = r_mode_changed;

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Directed bench for filter_mode_scheduler: a 4-mode instance (A) and a
// 3-mode instance (B), both with DEBOUNCE_CYCLES=4 and AUTO_FRAMES=3.
module tb_filter_mode_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_mode_scheduler_if #(.NUM_MODES(4)) busA ();
  filter_mode_scheduler_if #(.NUM_MODES(3)) busB ();

  filter_mode_scheduler #(
    .NUM_MODES(4), .DEBOUNCE_CYCLES(4), .AUTO_FRAMES(3)
  ) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );

  filter_mode_scheduler #(
    .NUM_MODES(3), .DEBOUNCE_CYCLES(4), .AUTO_FRAMES(3)
  ) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clean press on A: 6 high samples then 5 low samples back to IDLE.
  task automatic pressA();
    busA.btn_next = 1'b1;
    repeat (6) step();
    busA.btn_next = 1'b0;
    repeat (5) step();
  endtask

  task automatic pressB();
    busB.btn_next = 1'b1;
    repeat (6) step();
    busB.btn_next = 1'b0;
    repeat (5) step();
  endtask

  task automatic sofA();
    busA.sof = 1'b1;
    step();
    busA.sof = 1'b0;
  endtask

  task automatic sofB();
    busB.sof = 1'b1;
    step();
    busB.sof = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL reset_active got %0d exp 0", busA.mode_active); end
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL reset_pending got %0d exp 0", busA.mode_pending); end
    checks++; if (busA.filter_sel !== 4'b0001) begin errors++; $display("[TB] FAIL reset_sel got %b exp 0001", busA.filter_sel); end
    checks++; if (busA.mode_changed !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed got %b exp 0", busA.mode_changed); end
    checks++; if (busB.filter_sel !== 3'b001) begin errors++; $display("[TB] FAIL reset_selB got %b exp 001", busB.filter_sel); end
  endtask

  task automatic test_press();
    busA.btn_next = 1'b1;
    repeat (4) step();
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL press_early got %0d exp 0", busA.mode_pending); end
    step();
    checks++; if (busA.mode_pending !== 2'd1) begin errors++; $display("[TB] FAIL press_pending got %0d exp 1", busA.mode_pending); end
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL press_active_hold got %0d exp 0", busA.mode_active); end
    repeat (5) step();
    busA.btn_next = 1'b0;
    repeat (5) step();
    checks++; if (busA.mode_pending !== 2'd1) begin errors++; $display("[TB] FAIL press_no_repeat got %0d exp 1", busA.mode_pending); end
    sofA();
    checks++; if (busA.mode_active !== 2'd1) begin errors++; $display("[TB] FAIL press_commit got %0d exp 1", busA.mode_active); end
    checks++; if (busA.filter_sel !== 4'b0010) begin errors++; $display("[TB] FAIL press_sel got %b exp 0010", busA.filter_sel); end
    checks++; if (busA.mode_changed !== 1'b1) begin errors++; $display("[TB] FAIL press_changed got %b exp 1", busA.mode_changed); end
    step();
    checks++; if (busA.mode_changed !== 1'b0) begin errors++; $display("[TB] FAIL press_changed_once got %b exp 0", busA.mode_changed); end
  endtask

  task automatic test_bounce();
    logic [6:0] pattern;
    pattern = 7'b1101110;
    for (int i = 6; i >= 0; i--) begin
      busA.btn_next = pattern[i];
      step();
    end
    busA.btn_next = 1'b0;
    repeat (2) step();
    checks++; if (busA.mode_pending !== 2'd1) begin errors++; $display("[TB] FAIL bounce_pending got %0d exp 1", busA.mode_pending); end
    busA.btn_next = 1'b1;
    repeat (6) step();
    checks++; if (busA.mode_pending !== 2'd2) begin errors++; $display("[TB] FAIL bounce_press got %0d exp 2", busA.mode_pending); end
    busA.btn_next = 1'b0;
    repeat (2) step();
    busA.btn_next = 1'b1;
    repeat (3) step();
    busA.btn_next = 1'b0;
    repeat (5) step();
    checks++; if (busA.mode_pending !== 2'd2) begin errors++; $display("[TB] FAIL held_glitch got %0d exp 2", busA.mode_pending); end
    sofA();
    checks++; if (busA.mode_active !== 2'd2) begin errors++; $display("[TB] FAIL bounce_commit got %0d exp 2", busA.mode_active); end
    checks++; if (busA.mode_changed !== 1'b1) begin errors++; $display("[TB] FAIL bounce_changed got %b exp 1", busA.mode_changed); end
  endtask

  task automatic test_wrap();
    pressA();
    pressA();
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL wrap_pending got %0d exp 0", busA.mode_pending); end
    checks++; if (busA.mode_active !== 2'd2) begin errors++; $display("[TB] FAIL wrap_active_hold got %0d exp 2", busA.mode_active); end
    sofA();
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL wrap_commit got %0d exp 0", busA.mode_active); end
    checks++; if (busA.filter_sel !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_sel got %b exp 0001", busA.filter_sel); end
    checks++; if (busA.mode_changed !== 1'b1) begin errors++; $display("[TB] FAIL wrap_changed got %b exp 1", busA.mode_changed); end
    pressB();
    pressB();
    checks++; if (busB.mode_pending !== 2'd2) begin errors++; $display("[TB] FAIL wrapB_pending2 got %0d exp 2", busB.mode_pending); end
    sofB();
    checks++; if (busB.filter_sel !== 3'b100) begin errors++; $display("[TB] FAIL wrapB_sel2 got %b exp 100", busB.filter_sel); end
    pressB();
    checks++; if (busB.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL wrapB_pending0 got %0d exp 0", busB.mode_pending); end
    sofB();
    checks++; if (busB.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL wrapB_commit got %0d exp 0", busB.mode_active); end
    checks++; if (busB.filter_sel !== 3'b001) begin errors++; $display("[TB] FAIL wrapB_sel0 got %b exp 001", busB.filter_sel); end
    checks++; if (busB.mode_changed !== 1'b1) begin errors++; $display("[TB] FAIL wrapB_changed got %b exp 1", busB.mode_changed); end
    step();
    sofB();
    checks++; if (busB.mode_changed !== 1'b0) begin errors++; $display("[TB] FAIL wrapB_nochange got %b exp 0", busB.mode_changed); end
  endtask

  task automatic test_auto();
    logic [1:0] expMode;
    logic       expChg;
    busA.auto_en = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      expMode = 2'((k / 3) % 4);
      expChg  = (k % 3 == 0);
      sofA();
      checks++; if (busA.mode_active !== expMode) begin errors++; $display("[TB] FAIL auto_active sof %0d got %0d exp %0d", k, busA.mode_active, expMode); end
      checks++; if (busA.mode_changed !== expChg) begin errors++; $display("[TB] FAIL auto_changed sof %0d got %b exp %b", k, busA.mode_changed, expChg); end
      step();
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 8; k++) begin
      sofA();
      step();
    end
    checks++; if (busA.mode_active !== 2'd2) begin errors++; $display("[TB] FAIL simul_setup got %0d exp 2", busA.mode_active); end
    busA.btn_next = 1'b1;
    repeat (4) step();
    sofA();
    checks++; if (busA.mode_active !== 2'd3) begin errors++; $display("[TB] FAIL simul_active got %0d exp 3", busA.mode_active); end
    checks++; if (busA.mode_pending !== 2'd3) begin errors++; $display("[TB] FAIL simul_pending got %0d exp 3", busA.mode_pending); end
    checks++; if (busA.mode_changed !== 1'b1) begin errors++; $display("[TB] FAIL simul_changed got %b exp 1", busA.mode_changed); end
    repeat (5) step();
    busA.btn_next = 1'b0;
    repeat (5) step();
    sofA();
    checks++; if (busA.mode_active !== 2'd3) begin errors++; $display("[TB] FAIL simul_after1 got %0d exp 3", busA.mode_active); end
    pressA();
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL simul_press_wrap got %0d exp 0", busA.mode_pending); end
    sofA();
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL simul_commit0 got %0d exp 0", busA.mode_active); end
    step();
    sofA();
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL cnt_cleared got %0d exp 0", busA.mode_active); end
    step();
    sofA();
    checks++; if (busA.mode_active !== 2'd1) begin errors++; $display("[TB] FAIL cnt_fire got %0d exp 1", busA.mode_active); end
    busA.auto_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    pressA();
    sofA();
    pressA();
    checks++; if (busA.mode_active !== 2'd2) begin errors++; $display("[TB] FAIL rmid_active got %0d exp 2", busA.mode_active); end
    checks++; if (busA.mode_pending !== 2'd3) begin errors++; $display("[TB] FAIL rmid_pending got %0d exp 3", busA.mode_pending); end
    busA.btn_next = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busA.mode_active !== 2'd0) begin errors++; $display("[TB] FAIL rmid_reset_active got %0d exp 0", busA.mode_active); end
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL rmid_reset_pending got %0d exp 0", busA.mode_pending); end
    checks++; if (busA.filter_sel !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_reset_sel got %b exp 0001", busA.filter_sel); end
    checks++; if (busA.mode_changed !== 1'b0) begin errors++; $display("[TB] FAIL rmid_reset_changed got %b exp 0", busA.mode_changed); end
    repeat (4) step();
    checks++; if (busA.mode_pending !== 2'd0) begin errors++; $display("[TB] FAIL rmid_fresh_early got %0d exp 0", busA.mode_pending); end
    step();
    checks++; if (busA.mode_pending !== 2'd1) begin errors++; $display("[TB] FAIL rmid_fresh_press got %0d exp 1", busA.mode_pending); end
    busA.btn_next = 1'b0;
    repeat (5) step();
  endtask

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    busA.btn_next = 1'b0; busA.auto_en = 1'b0; busA.sof = 1'b0;
    busB.btn_next = 1'b0; busB.auto_en = 1'b0; busB.sof = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_wrap();
    test_auto();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_mode_scheduler.md
# filter_mode_scheduler

Selects which pixel filter (passthrough, inversion, grayscale, threshold, …) drives the RGB444 video path. Mode changes are requested by a push button or an auto-cycle timer and committed only on a start-of-frame pulse, so a frame is never split between two filters. It sits between the board button/switch inputs and the filter mux ahead of the VGA output. Its one-hot select directly gates the per-filter output mux.

## Interface
- `NUM_MODES`, default 4: number of selectable filters; must be at least 2.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a button edge; must be at least 2.
- `AUTO_FRAMES`, default 60: frames per mode in auto-cycle; must be at least 1.
- `MW`, default $clog2(NUM_MODES): mode index width.

Ports:
- `clk`  in  1: pixel-domain clock.
- `reset`  in  1: synchronous, active-high.
- `btn_next`  in  1: next-mode button; already synchronised to `clk`; active-high level.
- `auto_en`  in  1: enables auto-cycle; level.
- `sof`  in  1: start-of-frame strobe; one cycle per frame.
- `mode_active`  out  MW: committed mode index, which the filter mux uses.
- `mode_pending`  out  MW: mode that will be committed at the next `sof`.
- `filter_sel`  out  NUM_MODES: one-hot decode of `mode_active`.
- `mode_changed`  out  1: single-cycle pulse when a commit alters `mode_active`.

## Operation
- Debouncer FSM with four states:
  - IDLE: moves to PRESS_CNT when `btn_next` is 1.
  - PRESS_CNT: moves to IDLE if `btn_next` is 0. When DEBOUNCE_CYCLES consecutive 1 samples have been seen, it moves to HELD and asserts `press_evt` for one cycle.
  - HELD: moves to REL_CNT when `btn_next` is 0.
  - REL_CNT: moves to HELD if `btn_next` is 1. After DEBOUNCE_CYCLES consecutive 0 samples, it moves to IDLE.
  - A button held down produces exactly one `press_evt`, with no auto-repeat.
- Pending update on `press_evt`: `mode_pending` ← (`mode_pending` + 1) mod NUM_MODES, and the frame counter clears. Multiple presses within one frame accumulate.
- Frame counter: counts `sof` pulses from 0 to AUTO_FRAMES−1. It counts only while `auto_en` is 1 and clears while `auto_en` is 0.
- Commit on `sof`:
  - Compute `next_pending`:
    - If `press_evt` is 1 in the same cycle, it is `mode_pending`+1.
    - Otherwise, if the auto trigger fires and `mode_pending` equals `mode_active`, it is `mode_active`+1.
    - Otherwise it is `mode_pending`.
  - Then `mode_active` ← `next_pending` and `mode_pending` ← `next_pending`.
- Auto trigger: `auto_en` is 1, `sof` is 1, and the counter equals AUTO_FRAMES−1. The counter then wraps to 0.
- A manual request takes priority over the auto trigger, so a single `sof` never advances the mode by 2.
- All modulo arithmetic is done in MW bits, with an explicit wrap from NUM_MODES−1 to 0. This is required when NUM_MODES is not a power of two.
- Values of `mode_pending` at or above NUM_MODES are unreachable. `filter_sel` is never all-zero.

## Timing
- Values after reset:
  - `mode_active` = 0 (passthrough).
  - `mode_pending` = 0.
  - `filter_sel` = 1.
  - `mode_changed` = 0.
  - Debouncer in IDLE, counters at 0.
- `press_evt` asserts in the cycle after the DEBOUNCE_CYCLES-th consecutive high sample. `mode_pending` updates on the following edge.
- The commit takes effect on the clock edge that samples `sof` = 1. `mode_active` and `filter_sel` are valid in the first cycle after `sof`.
- `mode_changed` is registered: it is high for exactly the first cycle after `sof`, and only if the value changed.
- `reset` mid-frame or mid-debounce returns everything to the reset values on the next edge. A button held through reset is accepted only after a fresh DEBOUNCE_CYCLES count.
- Back-to-back `sof` pulses (a test-only case) each commit independently.

## Structure
- Shared package `vfx_pkg`:
  - `filter_mode_e`: MODE_PASS = 0, MODE_INVERT = 1, MODE_GRAY = 2, MODE_THRESH = 3.
  - `NUM_FILTER_MODES` = 4.
  - `PIXEL_W` = 12.
- Sub-module `button_debouncer`: the four-state FSM plus a $clog2(DEBOUNCE_CYCLES+1)-bit counter. It outputs `press_evt`.
- The top level holds the pending/active registers, the frame counter and the one-hot decode.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and AUTO_FRAMES = 3.
- Press: `btn_next` high for 10 cycles → one `press_evt`. `mode_pending` = 1 while `mode_active` stays 0. At the next `sof`, `mode_active` = 1, `filter_sel` = 0b0010, and `mode_changed` pulses once.
- Bounce: `btn_next` toggles 1,1,0,1,1,1,0 → no `press_evt` and `mode_pending` stays 0. A release glitch while in HELD produces no second event.
- Wrap: three presses within one frame from mode 1 → `mode_pending` = 0. At `sof`, `mode_active` = 0 and `filter_sel` = 0b0001. Repeat with NUM_MODES = 3 to check the non-power-of-two wrap.
- Auto: `auto_en` = 1 with no presses → `mode_active` advances 0→1→2→3→0 on every third `sof`, with `mode_changed` only on those frames.
- Simultaneous: `press_evt` and the auto trigger on the same `sof` with `mode_active` = 2 → `mode_active` = 3, not 0, and the frame counter clears.
- Reset: assert `reset` with `mode_active` = 2, `mode_pending` = 3 and the debounce count at 3 → all outputs return to their reset values. With the button still held, a new press is accepted only after 4 further high cycles.
